spram_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one single-port RAM (write-first, one-cycle registered read) between requesters A and B. It sits between two client engines and the RAM port. It grants at most one access per cycle, drives the RAM address, data and write-enable, and routes the RAM output back to the requester that was granted one cycle earlier. Sustained throughput is one access per cycle with no bubbles.

---
 rtl/spram_arb_pkg.sv | 12 +
 rtl/spram_arbiter_rr_arbiter2.sv | 43 ++++
 rtl/spram_arbiter.sv | 127 ++++++++++++
 tb/tb_spram_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_arb_pkg.sv
// Shared types and constants for the two-requester single-port RAM arbiter.
package spram_arb_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  localparam int unsigned STATS_CNT_WIDTH = 16;
  localparam logic [STATS_CNT_WIDTH-1:0] STATS_CNT_MAX = '1;

endpackage

// File: rtl/spram_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic; `last` remembers the most recent winner.
module rr_arbiter2
  import spram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e last_q, last_d;

  // Bit 0 is requester A, bit 1 is requester B; ties go to whoever did not win last.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_q == REQ_B) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt[0]) begin
      last_d = REQ_A;
    end else if (gnt[1]) begin
      last_d = REQ_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one write-first single-port RAM between requesters A and B.
// Optional grant counters are enabled by defining SPRAM_ARB_STATS_EN.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q
`ifdef SPRAM_ARB_STATS_EN
  ,
  input  logic                       stats_clr,
  output logic [STATS_CNT_WIDTH-1:0] a_gnt_count,
  output logic [STATS_CNT_WIDTH-1:0] b_gnt_count
`endif
);

  logic [1:0] gnt;
  logic       pending_q, pending_d;
  req_id_e    owner_q, owner_d;

  rr_arbiter2 u_rr_arbiter2 (
    .clk (clk),
    .rst (rst),
    .req ({b_req, a_req}),
    .gnt (gnt)
  );

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  always_comb begin
    ram_we      = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    if (gnt[0]) begin
      ram_we      = a_we;
      ram_address = a_addr;
      ram_data    = a_wdata;
    end else if (gnt[1]) begin
      ram_we      = b_we;
      ram_address = b_addr;
      ram_data    = b_wdata;
    end
  end

  always_comb begin
    pending_d = |gnt;
    owner_d   = owner_q;
    if (gnt[0]) begin
      owner_d = REQ_A;
    end else if (gnt[1]) begin
      owner_d = REQ_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      owner_q   <= REQ_A;
    end else begin
      pending_q <= pending_d;
      owner_q   <= owner_d;
    end
  end

  // rst masks rvalid combinationally so a response due during reset is dropped.
  assign a_rvalid = pending_q && (owner_q == REQ_A) && !rst;
  assign b_rvalid = pending_q && (owner_q == REQ_B) && !rst;
  assign a_rdata  = ram_q;
  assign b_rdata  = ram_q;

`ifdef SPRAM_ARB_STATS_EN
  logic [STATS_CNT_WIDTH-1:0] a_cnt_q, a_cnt_d;
  logic [STATS_CNT_WIDTH-1:0] b_cnt_q, b_cnt_d;

  // Clear wins over a same-cycle grant; counts saturate rather than wrap.
  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (stats_clr) begin
      a_cnt_d = '0;
      b_cnt_d = '0;
    end else begin
      if (gnt[0] && (a_cnt_q != STATS_CNT_MAX)) begin
        a_cnt_d = a_cnt_q + 1'b1;
      end
      if (gnt[1] && (b_cnt_q != STATS_CNT_MAX)) begin
        b_cnt_d = b_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign a_gnt_count = a_cnt_q;
  assign b_gnt_count = b_cnt_q;
`endif

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter with a behavioural write-first RAM beside it.
module tb_spram_arbiter;
  import spram_arb_pkg::*;

  localparam int AW = 7;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid, ram_we;
  logic [DW-1:0] a_rdata, b_rdata, ram_data, ram_q;
  logic [AW-1:0] ram_address;
`ifdef SPRAM_ARB_STATS_EN
  logic          stats_clr = 1'b0;
  logic [15:0]   a_gnt_count, b_gnt_count;
  int            a_cnt_m = 0, b_cnt_m = 0;
`endif

  spram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_address(ram_address), .ram_data(ram_data),
    .ram_q(ram_q)
`ifdef SPRAM_ARB_STATS_EN
    , .stats_clr(stats_clr), .a_gnt_count(a_gnt_count), .b_gnt_count(b_gnt_count)
`endif
  );

  // Write-first RAM with a preload port used only while the arbiter is in reset.
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic [DW-1:0] mem [0:127];
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_we) begin
      mem[ram_address] <= ram_data;
      ram_q            <= ram_data;
    end else ram_q <= mem[ram_address];
  end

  // Reference model state: memory contents, last winner, response in flight.
  logic [DW-1:0] ref_mem [0:127];
  int            prev_winner = 1;
  bit            resp_valid = 0;
  int            resp_who = -1;
  logic [DW-1:0] resp_data = '0;
  int            vectors = 0, miscompares = 0;

  logic [1:0]    obs_gnt;
  logic          obs_a_rvalid, obs_b_rvalid;
  logic [DW-1:0] obs_a_rdata, obs_b_rdata;

  task automatic cycle();
    int            win;
    logic          e_we, e_arv, e_brv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    @(negedge clk);
    win = -1;
    if (!rst) begin
      if (a_req && b_req) win = (prev_winner == 1) ? 0 : 1;
      else if (a_req) win = 0;
      else if (b_req) win = 1;
    end
    e_we   = (win == 0) ? a_we    : (win == 1) ? b_we    : 1'b0;
    e_addr = (win == 0) ? a_addr  : (win == 1) ? b_addr  : '0;
    e_data = (win == 0) ? a_wdata : (win == 1) ? b_wdata : '0;
    e_arv  = !rst && resp_valid && (resp_who == 0);
    e_brv  = !rst && resp_valid && (resp_who == 1);
    obs_gnt = {b_gnt, a_gnt};
    obs_a_rvalid = a_rvalid; obs_b_rvalid = b_rvalid;
    obs_a_rdata = a_rdata;   obs_b_rdata = b_rdata;

    vectors++;
    if (a_gnt !== (win == 0)) begin miscompares++; $display("FAIL a_gnt t=%0t got %b exp %b", $time, a_gnt, win == 0); end
    vectors++;
    if (b_gnt !== (win == 1)) begin miscompares++; $display("FAIL b_gnt t=%0t got %b exp %b", $time, b_gnt, win == 1); end
    vectors++;
    if (ram_we !== e_we) begin miscompares++; $display("FAIL ram_we t=%0t got %b exp %b", $time, ram_we, e_we); end
    vectors++;
    if (ram_address !== e_addr) begin miscompares++; $display("FAIL ram_address t=%0t got %h exp %h", $time, ram_address, e_addr); end
    vectors++;
    if (ram_data !== e_data) begin miscompares++; $display("FAIL ram_data t=%0t got %h exp %h", $time, ram_data, e_data); end
    vectors++;
    if (a_rvalid !== e_arv) begin miscompares++; $display("FAIL a_rvalid t=%0t got %b exp %b", $time, a_rvalid, e_arv); end
    vectors++;
    if (b_rvalid !== e_brv) begin miscompares++; $display("FAIL b_rvalid t=%0t got %b exp %b", $time, b_rvalid, e_brv); end
    if (e_arv) begin
      vectors++;
      if (a_rdata !== resp_data) begin miscompares++; $display("FAIL a_rdata t=%0t got %h exp %h", $time, a_rdata, resp_data); end
    end
    if (e_brv) begin
      vectors++;
      if (b_rdata !== resp_data) begin miscompares++; $display("FAIL b_rdata t=%0t got %h exp %h", $time, b_rdata, resp_data); end
    end
`ifdef SPRAM_ARB_STATS_EN
    vectors++;
    if (a_gnt_count !== a_cnt_m[15:0]) begin miscompares++; $display("FAIL a_gnt_count t=%0t got %0d exp %0d", $time, a_gnt_count, a_cnt_m); end
    vectors++;
    if (b_gnt_count !== b_cnt_m[15:0]) begin miscompares++; $display("FAIL b_gnt_count t=%0t got %0d exp %0d", $time, b_gnt_count, b_cnt_m); end
    if (rst || stats_clr) begin a_cnt_m = 0; b_cnt_m = 0; end
    else begin
      if (win == 0 && a_cnt_m < 65535) a_cnt_m++;
      if (win == 1 && b_cnt_m < 65535) b_cnt_m++;
    end
`endif
    if (win >= 0) begin
      resp_data = e_we ? e_data : ref_mem[e_addr];
      if (e_we) ref_mem[e_addr] = e_data;
      prev_winner = win;
    end
    resp_valid = (win >= 0);
    resp_who   = win;
    if (rst) prev_winner = 1;
    if (pl_en) ref_mem[pl_addr] = pl_data;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
    pl_en = 1'b1;
    for (int i = 0; i < 128; i++) begin
      pl_addr = 7'(i);
      pl_data = (i == 5) ? 8'h3C : 8'($urandom);
      cycle();
    end
    pl_en = 1'b0; a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_single_read();
    a_req = 1'b1; a_we = 1'b0; a_addr = 7'd5;
    cycle();
    vectors++;
    if (obs_gnt !== 2'b01) begin miscompares++; $display("FAIL single_gnt got %b exp 01", obs_gnt); end
    a_req = 1'b0;
    cycle();
    vectors++;
    if (obs_a_rvalid !== 1'b1 || obs_a_rdata !== 8'h3C || obs_b_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_resp got rv=%b d=%h brv=%b exp rv=1 d=3c brv=0", obs_a_rvalid, obs_a_rdata, obs_b_rvalid);
    end
  endtask

  task automatic test_contention();
    do_reset(2);
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_addr = 7'($urandom); b_addr = 7'($urandom);
      cycle();
      vectors++;
      if (obs_gnt !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        miscompares++; $display("FAIL contention_gnt i=%0d got %b exp %b", i, obs_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    cycle();
  endtask

  task automatic test_write_then_read();
    b_req = 1'b1; b_we = 1'b1; b_addr = 7'h7F; b_wdata = 8'h5A;
    cycle();
    b_req = 1'b0; b_we = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 7'h7F;
    cycle();
    vectors++;
    if (obs_b_rvalid !== 1'b1 || obs_b_rdata !== 8'h5A) begin
      miscompares++; $display("FAIL wtr_b got rv=%b d=%h exp rv=1 d=5a", obs_b_rvalid, obs_b_rdata);
    end
    a_req = 1'b0;
    cycle();
    vectors++;
    if (obs_a_rvalid !== 1'b1 || obs_a_rdata !== 8'h5A) begin
      miscompares++; $display("FAIL wtr_a got rv=%b d=%h exp rv=1 d=5a", obs_a_rvalid, obs_a_rdata);
    end
  endtask

  task automatic test_reset_mid();
    a_req = 1'b1; a_we = 1'b1; a_addr = 7'h10; a_wdata = 8'hA5;
    cycle();
    rst = 1'b1; a_we = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 7'h00;
    cycle();
    vectors++;
    if (obs_a_rvalid !== 1'b0 || obs_gnt !== 2'b00) begin
      miscompares++; $display("FAIL mid_reset got rv=%b gnt=%b exp rv=0 gnt=00", obs_a_rvalid, obs_gnt);
    end
    rst = 1'b0;
    cycle();
    vectors++;
    if (obs_a_rvalid !== 1'b0 || obs_gnt !== 2'b01) begin
      miscompares++; $display("FAIL post_reset got rv=%b gnt=%b exp rv=0 gnt=01", obs_a_rvalid, obs_gnt);
    end
    a_req = 1'b0;
    cycle();
    vectors++;
    if (obs_a_rdata !== 8'hA5 || obs_gnt !== 2'b10) begin
      miscompares++; $display("FAIL write_survives got d=%h gnt=%b exp d=a5 gnt=10", obs_a_rdata, obs_gnt);
    end
    b_req = 1'b0;
    cycle();
  endtask

  task automatic test_idle();
    cycle();
    cycle();
    vectors++;
    if (obs_a_rvalid !== 1'b0 || obs_b_rvalid !== 1'b0 || obs_gnt !== 2'b00) begin
      miscompares++; $display("FAIL idle got arv=%b brv=%b gnt=%b exp 0 0 00", obs_a_rvalid, obs_b_rvalid, obs_gnt);
    end
    a_req = 1'b1; b_req = 1'b1;
    cycle();
    vectors++;
    if (obs_gnt !== 2'b01) begin miscompares++; $display("FAIL idle_last got gnt=%b exp 01", obs_gnt); end
    a_req = 1'b0; b_req = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      cycle();
      if (obs_gnt[0] || !a_req) begin
        a_req = ($urandom_range(0, 3) != 0); a_we = $urandom_range(0, 1);
        a_addr = 7'($urandom) & (($urandom_range(0, 1) != 0) ? 7'h0F : 7'h7F);
        a_wdata = 8'($urandom);
      end
      if (obs_gnt[1] || !b_req) begin
        b_req = ($urandom_range(0, 3) != 0); b_we = $urandom_range(0, 1);
        b_addr = 7'($urandom) & (($urandom_range(0, 1) != 0) ? 7'h0F : 7'h7F);
        b_wdata = 8'($urandom);
      end
    end
    rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
    cycle();
  endtask

`ifdef SPRAM_ARB_STATS_EN
  task automatic test_stats();
    do_reset(1);
    a_req = 1'b1; a_we = 1'b0; b_req = 1'b0;
    repeat (70000) cycle();
    vectors++;
    if (a_gnt_count !== 16'hFFFF) begin miscompares++; $display("FAIL stats_sat got %h exp ffff", a_gnt_count); end
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    a_req = 1'b0;
    cycle();
    vectors++;
    if (a_gnt_count !== 16'h0000) begin miscompares++; $display("FAIL stats_clr got %h exp 0000", a_gnt_count); end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_single_read();
    test_contention();
    test_write_then_read();
    test_reset_mid();
    test_idle();
    test_random();
`ifdef SPRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
